// File: rtl/dly_cmd_sequencer.sv
// Delay-line command sequencer: buffers load/increment/decrement commands in a
// small FIFO and plays them out as load/adjust strobes to a delay address decoder.
module dly_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [4:0] cmd_addr_i,
    input  logic [1:0] cmd_op_i,
    input  logic [5:0] cmd_steps_i,
    output logic       dly_load_o,
    output logic       dly_adj_o,
    output logic       dly_incdec_o,
    output logic [4:0] dly_addr_o,
    output logic       busy_o,
    output logic       cmd_err_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        GAP
    } state_t;

    state_t state_q, state_d;

    logic [4:0] addrMem_q  [FIFO_DEPTH];
    logic [1:0] opMem_q    [FIFO_DEPTH];
    logic [5:0] stepsMem_q [FIFO_DEPTH];

    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0] count_q;

    logic [5:0]       remaining_q, remaining_d;
    logic [GAP_W-1:0] gapCnt_q, gapCnt_d;
    logic             isLoad_q, isLoad_d;
    logic [4:0]       addr_q, addr_d;
    logic             incdec_q, incdec_d;
    logic             load_q, load_d;
    logic             adj_q, adj_d;
    logic             cmdErr_q;

    logic accept, illegal, push, pop;
    logic [4:0] headAddr;
    logic [1:0] headOp;
    logic [5:0] headSteps;

    assign cmd_ready_o = (count_q != CNT_W'(FIFO_DEPTH));
    assign accept      = cmd_valid_i && cmd_ready_o;

    // Out-of-range channel, reserved opcode, or an adjust with nothing to do.
    assign illegal = (cmd_addr_i >= 5'd20) ||
                     (cmd_op_i == 2'b11) ||
                     (((cmd_op_i == OP_INC) || (cmd_op_i == OP_DEC)) && (cmd_steps_i == 6'd0));

    assign push = accept && !illegal;
    assign pop  = (state_q == IDLE) && (count_q != '0);

    assign headAddr  = addrMem_q[rdPtr_q];
    assign headOp    = opMem_q[rdPtr_q];
    assign headSteps = stepsMem_q[rdPtr_q];

    always_ff @(posedge clk_i) begin
        if (push) begin
            addrMem_q[wrPtr_q]  <= cmd_addr_i;
            opMem_q[wrPtr_q]    <= cmd_op_i;
            stepsMem_q[wrPtr_q] <= cmd_steps_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        gapCnt_d    = gapCnt_q;
        isLoad_d    = isLoad_q;
        addr_d      = addr_q;
        incdec_d    = incdec_q;
        load_d      = 1'b0;
        adj_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d     = SETUP;
                    addr_d      = headAddr;
                    incdec_d    = (headOp == OP_INC);
                    isLoad_d    = (headOp == OP_LOAD);
                    remaining_d = (headOp == OP_LOAD) ? 6'd1 : headSteps;
                end
            end
            SETUP: begin
                state_d = PULSE;
            end
            PULSE: begin
                remaining_d = remaining_q - 6'd1;
                if (remaining_q > 6'd1) begin
                    state_d  = GAP;
                    gapCnt_d = GAP_W'(GAP_CYCLES - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gapCnt_q == '0) begin
                    state_d = PULSE;
                end else begin
                    gapCnt_d = gapCnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes are registered, so they are decided by the state being entered.
        if (state_d == PULSE) begin
            load_d = isLoad_q;
            adj_d  = !isLoad_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            gapCnt_q    <= '0;
            isLoad_q    <= 1'b0;
            addr_q      <= 5'd0;
            incdec_q    <= 1'b0;
            load_q      <= 1'b0;
            adj_q       <= 1'b0;
            cmdErr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            gapCnt_q    <= gapCnt_d;
            isLoad_q    <= isLoad_d;
            addr_q      <= addr_d;
            incdec_q    <= incdec_d;
            load_q      <= load_d;
            adj_q       <= adj_d;
            cmdErr_q    <= accept && illegal;
        end
    end

    assign dly_load_o   = load_q;
    assign dly_adj_o    = adj_q;
    assign dly_incdec_o = incdec_q;
    assign dly_addr_o   = addr_q;
    assign cmd_err_o    = cmdErr_q;
    assign busy_o       = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_dly_cmd_sequencer.sv
// Randomized bench for dly_cmd_sequencer: a command-level timeline model predicts
// every output each cycle (pulse k of a command lands GAP+1 cycles after pulse k-1).
module tb_dly_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int GAP   = 2;

    typedef struct packed {
        logic [4:0] addr;
        logic [1:0] op;
        logic [5:0] steps;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rstN;
    logic       cmdValid;
    logic [4:0] cmdAddr;
    logic [1:0] cmdOp;
    logic [5:0] cmdSteps;
    logic       cmdReady;
    logic       dlyLoad;
    logic       dlyAdj;
    logic       dlyIncdec;
    logic [4:0] dlyAddr;
    logic       busy;
    logic       cmdErr;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: pending queue plus the cycle index of the running command.
    cmd_t       mQ[$];
    bit         mActive;
    int         mT;
    cmd_t       mCur;
    logic       eLoad, eAdj, eIncdec, eErr;
    logic [4:0] eAddr;

    always #5 clk = ~clk;

    dly_cmd_sequencer #(
        .FIFO_DEPTH(DEPTH),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .cmd_valid_i (cmdValid),
        .cmd_ready_o (cmdReady),
        .cmd_addr_i  (cmdAddr),
        .cmd_op_i    (cmdOp),
        .cmd_steps_i (cmdSteps),
        .dly_load_o  (dlyLoad),
        .dly_adj_o   (dlyAdj),
        .dly_incdec_o(dlyIncdec),
        .dly_addr_o  (dlyAddr),
        .busy_o      (busy),
        .cmd_err_o   (cmdErr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Cycle index (1 = setup cycle) of the final strobe of a command.
    function automatic int lastT(input cmd_t c);
        int s;
        s = (c.op == 2'b00) ? 1 : int'(c.steps);
        return 2 + (s - 1) * (GAP + 1);
    endfunction

    function automatic bit isPulse(input int t, input cmd_t c);
        return (t >= 2) && (t <= lastT(c)) && (((t - 2) % (GAP + 1)) == 0);
    endfunction

    function automatic bit isIllegal(input cmd_t c);
        return (c.addr >= 5'd20) || (c.op == 2'b11) || ((c.op != 2'b00) && (c.steps == 6'd0));
    endfunction

    task automatic modelEdge();
        bit   acc;
        cmd_t inC;
        if (!rstN) begin
            mQ.delete();
            mActive = 1'b0;
            mT      = 0;
            eLoad   = 1'b0;
            eAdj    = 1'b0;
            eIncdec = 1'b0;
            eErr    = 1'b0;
            eAddr   = 5'd0;
        end else begin
            acc       = cmdValid && (mQ.size() < DEPTH);
            inC.addr  = cmdAddr;
            inC.op    = cmdOp;
            inC.steps = cmdSteps;
            if (mActive) begin
                mT++;
                if (mT > lastT(mCur)) mActive = 1'b0;
            end else if (mQ.size() > 0) begin
                mCur    = mQ.pop_front();
                mActive = 1'b1;
                mT      = 1;
                eAddr   = mCur.addr;
                eIncdec = (mCur.op == 2'b01);
            end
            eLoad = mActive && isPulse(mT, mCur) && (mCur.op == 2'b00);
            eAdj  = mActive && isPulse(mT, mCur) && (mCur.op != 2'b00);
            eErr  = acc && isIllegal(inC);
            if (acc && !isIllegal(inC)) mQ.push_back(inC);
        end
    endtask

    task automatic checkAll();
        checkOutput("cmd_ready", 32'(cmdReady), 32'(mQ.size() < DEPTH));
        checkOutput("busy", 32'(busy), 32'((mQ.size() > 0) || mActive));
        checkOutput("dly_load", 32'(dlyLoad), 32'(eLoad));
        checkOutput("dly_adj", 32'(dlyAdj), 32'(eAdj));
        checkOutput("dly_addr", 32'(dlyAddr), 32'(eAddr));
        checkOutput("dly_incdec", 32'(dlyIncdec), 32'(eIncdec));
        checkOutput("cmd_err", 32'(cmdErr), 32'(eErr));
    endtask

    // One clock cycle: drive at the falling edge, model at the rising edge, check at the next falling edge.
    task automatic applyStimulus(input bit rn, input bit v, input logic [4:0] a,
                                 input logic [1:0] op, input logic [5:0] s);
        rstN     = rn;
        cmdValid = v;
        cmdAddr  = a;
        cmdOp    = op;
        cmdSteps = s;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkAll();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 5'd0, 2'b00, 6'd0);
    endtask

    // Holds the command valid until the model says there was room for it.
    task automatic sendCmd(input logic [4:0] a, input logic [1:0] op, input logic [5:0] s);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            done = (mQ.size() < DEPTH);
            applyStimulus(1'b1, 1'b1, a, op, s);
        end
        if (!done) checkOutput("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rstN     = 1'b0;
        cmdValid = 1'b0;
        cmdAddr  = 5'd0;
        cmdOp    = 2'b00;
        cmdSteps = 6'd0;
        @(negedge clk);

        // Reset, with a command presented that must be ignored.
        applyStimulus(1'b0, 1'b1, 5'd3, 2'b01, 6'd2);
        applyStimulus(1'b0, 1'b0, 5'd0, 2'b00, 6'd0);
        idle(2);

        // Single load to channel 7.
        sendCmd(5'd7, 2'b00, 6'd0);
        idle(6);

        // Increment channel 19 by 3 steps.
        sendCmd(5'd19, 2'b01, 6'd3);
        idle(12);

        // Three illegal commands.
        sendCmd(5'd20, 2'b00, 6'd1);
        sendCmd(5'd3, 2'b11, 6'd5);
        sendCmd(5'd3, 2'b10, 6'd0);
        idle(3);

        // Five commands back-to-back to fill the FIFO.
        sendCmd(5'd1, 2'b01, 6'd2);
        sendCmd(5'd2, 2'b00, 6'd9);
        sendCmd(5'd3, 2'b10, 6'd1);
        sendCmd(5'd4, 2'b01, 6'd3);
        sendCmd(5'd5, 2'b00, 6'd0);
        idle(40);

        // Reset while a 10-step decrement sits in a gap with two commands queued.
        sendCmd(5'd9, 2'b10, 6'd10);
        sendCmd(5'd2, 2'b01, 6'd1);
        sendCmd(5'd4, 2'b00, 6'd0);
        idle(4);
        applyStimulus(1'b0, 1'b1, 5'd6, 2'b00, 6'd0);
        idle(2);
        sendCmd(5'd11, 2'b00, 6'd0);
        idle(6);

        // Random traffic, including illegal commands and rare resets.
        for (int i = 0; i < 500; i++) begin
            applyStimulus(($urandom_range(0, 199) != 0),
                          ($urandom_range(0, 1) == 1),
                          5'($urandom_range(0, 23)),
                          2'($urandom_range(0, 3)),
                          6'($urandom_range(0, 4)));
        end
        idle(80);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/dly_cmd_sequencer.md
DLY_CMD_SEQUENCER -- requirements
Module: DLY_CMD_SEQUENCER

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the number of buffered commands (power of 2, minimum 2).
REQ-003 Parameter GAP_CYCLES, default 2, SHALL set the number of idle cycles between adjust pulses (minimum 1).
REQ-004 Port CLK, input, 1 -- clock; all logic on its rising edge.
REQ-005 Port RST, input, 1 -- synchronous active-low reset.
REQ-006 Port CMD_VALID, input, 1 -- a command is presented.
REQ-007 Port CMD_READY, output, 1 -- the command can be accepted.
REQ-008 Port CMD_ADDR, input, 5 -- target delay channel, 0..19.
REQ-009 Port CMD_OP, input, 2 -- 00 load, 01 increment, 10 decrement, 11 reserved.
REQ-010 Port CMD_STEPS, input, 6 -- number of adjust pulses, 1..63 (ignored for load).
REQ-011 Port DLY_LOAD, output, 1 -- load strobe to the delay address decoder.
REQ-012 Port DLY_ADJ, output, 1 -- adjust strobe to the decoder.
REQ-013 Port DLY_INCDEC, output, 1 -- 1 = increment, 0 = decrement.
REQ-014 Port DLY_ADDR, output, 5 -- channel select to the decoder.
REQ-015 Port BUSY, output, 1 -- FIFO non-empty or sequencer not IDLE.
REQ-016 Port CMD_ERR, output, 1 -- one-cycle pulse when an illegal command is dropped.

Function
REQ-017 A command SHALL be accepted on any rising edge where CMD_VALID and CMD_READY are both 1.
- CMD_READY = FIFO not full; it is combinational from the FIFO count.
REQ-018 An accepted command SHALL be illegal if any of these holds:
- CMD_ADDR >= 20;
- CMD_OP = 11;
- CMD_OP in {01, 10} with CMD_STEPS = 0.
REQ-019 An illegal command SHALL NOT be written to the FIFO, and CMD_ERR SHALL be 1 for exactly the next cycle.
REQ-020 A legal command SHALL be written to the FIFO in acceptance order.
- Push and pop in the same cycle SHALL both take effect.
REQ-021 The sequencer states SHALL be IDLE, SETUP, PULSE, GAP.
REQ-022 IDLE with FIFO non-empty SHALL pop the head entry and go to SETUP on the same edge.
- Registers DLY_ADDR = entry address.
- Registers DLY_INCDEC = 1 for increment, 0 otherwise.
- Registers remaining = STEPS (1 for load).
REQ-023 SETUP SHALL last one cycle with both strobes at 0, then go to PULSE.
REQ-024 PULSE SHALL last one cycle.
- Drives DLY_LOAD = 1 for a load, DLY_ADJ = 1 for an adjust.
- Decrements remaining.
REQ-025 After PULSE the sequencer SHALL go to GAP if remaining > 0, else to IDLE.
REQ-026 GAP SHALL hold both strobes at 0 for GAP_CYCLES cycles, then go to PULSE.
REQ-027 DLY_ADDR and DLY_INCDEC SHALL stay stable from SETUP until the next pop.
- In IDLE they hold their last values.
REQ-028 DLY_LOAD and DLY_ADJ SHALL never be 1 in the same cycle, and SHALL be 0 outside PULSE.
REQ-029 Latency: a command accepted at the end of cycle n into an empty FIFO with the sequencer IDLE SHALL be timed as follows.
- Cycle n+2: DLY_ADDR valid.
- Cycle n+3: first strobe high.
REQ-030 An adjust of S steps SHALL produce S strobes with period GAP_CYCLES+1.
- Command occupies SETUP through the last PULSE: 1 + S + (S-1)*GAP_CYCLES cycles.
REQ-031 Back-to-back commands SHALL start with IDLE -> SETUP directly after the last PULSE of the previous command.
- Each command passes through IDLE for exactly one cycle.
- A SETUP cycle always separates a strobe from any address change.
REQ-032 All outputs SHALL be registered except CMD_READY and BUSY.

Reset
REQ-033 While RST = 0 at a rising edge, the following SHALL take effect on that edge.
- State <- IDLE; FIFO flushed; remaining <- 0.
- DLY_LOAD, DLY_ADJ, DLY_INCDEC, CMD_ERR <- 0; DLY_ADDR <- 5'd0.
REQ-034 Reset during SETUP, PULSE or GAP SHALL abort the command, discard pending pulses, and drop any strobe at that edge.
REQ-035 CMD_VALID SHALL be ignored at a reset edge, and CMD_READY SHALL be 1 after reset.

Verification
REQ-036 Load to channel 7 accepted in cycle 10 -> DLY_ADDR = 7 from cycle 12; DLY_LOAD = 1 only in cycle 13; DLY_ADJ stays 0; BUSY = 0 from cycle 14.
REQ-037 Increment, addr 19, 3 steps, GAP_CYCLES = 2 -> DLY_ADJ high in 3 single cycles spaced 3 apart; DLY_INCDEC = 1 throughout; DLY_ADDR = 19.
REQ-038 Addr 20, then op 11, then decrement with 0 steps -> CMD_ERR pulses once per command; no strobes; FIFO stays empty.
REQ-039 Five legal commands pushed back-to-back with FIFO_DEPTH = 4 while the first executes -> CMD_READY = 0 exactly when 4 entries are stored; all accepted commands execute in order; none lost.
REQ-040 RST = 0 during GAP of a 10-step decrement, with 2 commands queued -> no further strobes; BUSY = 0 and DLY_ADDR = 0 after the edge; a new load executes normally with the REQ-029 timing.
